// File: rtl/sb_split_ctrl.sv
// Slave-side split-transaction controller: answers SPLIT while the slave is busy,
// tracks the single outstanding owner and pulses its release bit on completion or watchdog expiry.
module sb_split_ctrl #(
  parameter int SB_NUM_MASTER = 2,
  parameter int SB_RESP_TYPE  = 2,
  parameter int TIMEOUT       = 16,
  parameter int CNT_W         = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sel,
  input  logic [SB_NUM_MASTER-1:0] sb_masters,
  input  logic                     sb_mastlock,
  input  logic                     slv_busy,
  input  logic                     slv_done,
  output logic [SB_RESP_TYPE-1:0]  sb_resp,
  output logic [SB_NUM_MASTER-1:0] sb_split_ar,
  output logic [SB_NUM_MASTER-1:0] slv_owner,
  output logic                     split_timeout
);

  typedef enum logic [1:0] {IDLE, SPLIT, WAIT, RELEASE} state_t;

  localparam logic [SB_RESP_TYPE-1:0] RESP_OKAY  = SB_RESP_TYPE'(0);
  localparam logic [SB_RESP_TYPE-1:0] RESP_ERROR = SB_RESP_TYPE'(1);
  localparam logic [SB_RESP_TYPE-1:0] RESP_RETRY = SB_RESP_TYPE'(2);
  localparam logic [SB_RESP_TYPE-1:0] RESP_SPLIT = SB_RESP_TYPE'(3);
  localparam logic [CNT_W-1:0]        CNT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]        CNT_MAX    = '1;

  state_t                     state, state_n;
  logic [CNT_W-1:0]           cnt, cnt_n;
  logic [SB_RESP_TYPE-1:0]    resp_n;
  logic [SB_NUM_MASTER-1:0]   ar_n, owner_n;
  logic                       to_n;
  logic                       legal;
  logic [SB_RESP_TYPE-1:0]    busy_resp;

  assign legal = (sb_masters != '0) && ((sb_masters & (sb_masters - 1'b1)) == '0);

  // Response to a transfer while a split is already outstanding: never split again.
  always_comb begin
    busy_resp = RESP_OKAY;
    if (sel) begin
      if (!legal)        busy_resp = RESP_ERROR;
      else if (slv_busy) busy_resp = RESP_RETRY;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    resp_n  = RESP_OKAY;
    ar_n    = '0;
    owner_n = slv_owner;
    to_n    = 1'b0;
    case (state)
      IDLE: begin
        if (sel) begin
          if (!legal)
            resp_n = RESP_ERROR;
          else if (slv_busy && sb_mastlock)
            resp_n = RESP_RETRY;
          else if (slv_busy) begin
            resp_n  = RESP_SPLIT;
            owner_n = sb_masters;
            cnt_n   = '0;
            state_n = SPLIT;
          end
        end
      end
      SPLIT: begin
        resp_n  = busy_resp;
        state_n = WAIT;
      end
      WAIT: begin
        resp_n = busy_resp;
        cnt_n  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        if (slv_done) begin
          ar_n    = slv_owner;
          state_n = RELEASE;
        end else if (cnt == CNT_LAST) begin
          ar_n    = slv_owner;
          to_n    = 1'b1;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        resp_n  = (sel && slv_busy) ? RESP_RETRY : RESP_OKAY;
        owner_n = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      sb_resp       <= RESP_OKAY;
      sb_split_ar   <= '0;
      slv_owner     <= '0;
      split_timeout <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      sb_resp       <= resp_n;
      sb_split_ar   <= ar_n;
      slv_owner     <= owner_n;
      split_timeout <= to_n;
    end
  end

endmodule

// File: tb/tb_sb_split_ctrl.sv
// Directed scoreboard bench: each driven cycle queues the outputs expected after the next edge.
module tb_sb_split_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic [1:0] sb_masters = '0;
  logic       sb_mastlock = 1'b0;
  logic       slv_busy = 1'b0;
  logic       slv_done = 1'b0;
  logic [1:0] sb_resp;
  logic [1:0] sb_split_ar;
  logic [1:0] slv_owner;
  logic       split_timeout;

  typedef struct packed {
    logic [1:0] resp;
    logic [1:0] ar;
    logic [1:0] own;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   id_q[$];
  int   sid = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  sb_split_ctrl #(.SB_NUM_MASTER(2), .SB_RESP_TYPE(2), .TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .sel(sel), .sb_masters(sb_masters), .sb_mastlock(sb_mastlock),
    .slv_busy(slv_busy), .slv_done(slv_done), .sb_resp(sb_resp), .sb_split_ar(sb_split_ar),
    .slv_owner(slv_owner), .split_timeout(split_timeout)
  );

  // Monitor: one queued expectation per sampling edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      exp_t g;
      int   id;
      e = exp_q.pop_front();
      id = id_q.pop_front();
      g = '{resp: sb_resp, ar: sb_split_ar, own: slv_owner, to: split_timeout};
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL step %0d: got resp=%b ar=%b own=%b to=%b, expected resp=%b ar=%b own=%b to=%b",
                 id, g.resp, g.ar, g.own, g.to, e.resp, e.ar, e.own, e.to);
      end
    end
  end

  task automatic cyc(input logic r, input logic s, input logic [1:0] m, input logic lk,
                     input logic bz, input logic dn, input logic [1:0] er, input logic [1:0] ea,
                     input logic [1:0] eo, input logic et);
    @(negedge clk);
    rst = r; sel = s; sb_masters = m; sb_mastlock = lk; slv_busy = bz; slv_done = dn;
    exp_q.push_back('{resp: er, ar: ea, own: eo, to: et});
    id_q.push_back(sid);
    sid++;
  endtask

  task automatic idle(input logic [1:0] er, input logic [1:0] ea, input logic [1:0] eo, input logic et);
    cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, er, ea, eo, et);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with random inputs
    for (int i = 0; i < 2; i++)
      cyc(1'b1, 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          2'b00, 2'b00, 2'b00, 1'b0);

    // Split master 01, foreign and owner retries, completion via slv_done
    cyc(0, 1, 2'b01, 0, 1, 0, 2'b11, 2'b00, 2'b01, 0);
    idle(2'b00, 2'b00, 2'b01, 0);
    cyc(0, 1, 2'b10, 0, 1, 0, 2'b10, 2'b00, 2'b01, 0);
    cyc(0, 1, 2'b01, 0, 1, 0, 2'b10, 2'b00, 2'b01, 0);
    cyc(0, 1, 2'b01, 0, 0, 0, 2'b00, 2'b00, 2'b01, 0);
    cyc(0, 0, 2'b00, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
    cyc(0, 1, 2'b10, 0, 1, 0, 2'b10, 2'b00, 2'b00, 0);
    cyc(0, 0, 2'b00, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0);

    // Locked retry, illegal masters, plain OKAY
    cyc(0, 1, 2'b01, 1, 1, 0, 2'b10, 2'b00, 2'b00, 0);
    cyc(0, 1, 2'b11, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
    cyc(0, 1, 2'b00, 0, 1, 0, 2'b01, 2'b00, 2'b00, 0);
    cyc(0, 1, 2'b10, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);

    // Watchdog release of master 10, 1+16 cycles after SPLIT
    cyc(0, 1, 2'b10, 0, 1, 0, 2'b11, 2'b00, 2'b10, 0);
    for (int i = 0; i < 16; i++) idle(2'b00, 2'b00, 2'b10, 0);
    idle(2'b00, 2'b10, 2'b10, 1);
    idle(2'b00, 2'b00, 2'b00, 0);
    idle(2'b00, 2'b00, 2'b00, 0);

    // slv_done coincident with the timeout: no timeout flag
    cyc(0, 1, 2'b01, 0, 1, 0, 2'b11, 2'b00, 2'b01, 0);
    for (int i = 0; i < 16; i++) idle(2'b00, 2'b00, 2'b01, 0);
    cyc(0, 0, 2'b00, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
    idle(2'b00, 2'b00, 2'b00, 0);

    // Reset in the third WAIT cycle drops the owner without a release pulse
    cyc(0, 1, 2'b01, 0, 1, 0, 2'b11, 2'b00, 2'b01, 0);
    idle(2'b00, 2'b00, 2'b01, 0);
    idle(2'b00, 2'b00, 2'b01, 0);
    idle(2'b00, 2'b00, 2'b01, 0);
    cyc(1, 0, 2'b00, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0);
    cyc(0, 0, 2'b00, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0);
    for (int i = 0; i < 18; i++) idle(2'b00, 2'b00, 2'b00, 0);

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
